// File: rtl/ps2_jump_decoder_if.sv
// PS/2 keyboard lines and decoded key/scan outputs of the jump-key decoder.
// The master side drives the PS/2 lines; the slave side is the decoder.
interface ps2_jump_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic       jump_key;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  jump_key,
    input  scan_code,
    input  scan_valid,
    input  frame_err
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output jump_key,
    output scan_code,
    output scan_valid,
    output frame_err
  );
endinterface

// File: rtl/ps2_jump_decoder.sv
// PS/2 set-2 receiver: frames bytes off ps2_clk falling edges and tracks the held state of JUMP_CODE.
// Optional PS2_CLK_FILTER_EN: 8-cycle deglitch on ps2_clk, adds 8 sysclk to scan_valid latency.
module ps2_jump_decoder #(
  parameter logic [7:0] JUMP_CODE      = 8'h29,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input logic               sysclk,
  input logic               reset,
  ps2_jump_decoder_if.slave bus
);

  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    EXT_PFX = 8'hE0;
  localparam logic [7:0]    BRK_PFX = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic          r_clk_prev;
  logic          w_clk_f;
  logic          w_fall;
  logic          w_timeout;
  logic          w_shift_en;
  logic          w_ok;
  logic          w_err;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic          r_ext_pending;
  logic          r_brk_pending;
  logic          r_jump_key;
  logic [7:0]    r_scan_code;
  logic          r_scan_valid;
  logic          r_frame_err;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= bus.ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= bus.ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

`ifdef PS2_CLK_FILTER_EN
  logic       r_clk_filt;
  logic [2:0] r_filt_cnt;

  // Level follows the synchronized clock only after 8 consecutive differing samples.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_clk_filt <= 1'b1;
      r_filt_cnt <= 3'd0;
    end else if (r_clk_s2 != r_clk_filt) begin
      if (r_filt_cnt == 3'd7) begin
        r_clk_filt <= r_clk_s2;
        r_filt_cnt <= 3'd0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 3'd1;
      end
    end else begin
      r_filt_cnt <= 3'd0;
    end
  end

  assign w_clk_f = r_clk_filt;
`else
  assign w_clk_f = r_clk_s2;
`endif

  assign w_fall    = r_clk_prev & ~w_clk_f;
  assign w_timeout = (r_state != IDLE) && (r_to_cnt == TO_LAST);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_clk_prev <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_prev <= w_clk_f;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    if (w_fall) begin
      case (r_state)
        IDLE: begin
          if (!r_dat_s2) w_state_nxt = DATA;
          else           w_err       = 1'b1;
        end
        DATA: begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
        end
        PARITY: w_state_nxt = STOP;
        STOP: begin
          w_state_nxt = IDLE;
          // Odd parity: data bits plus parity bit must XOR to 1.
          if (r_dat_s2 && (^{r_shift, r_par})) w_ok  = 1'b1;
          else                                  w_err = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = IDLE;
      w_err       = 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'h00;
      r_par         <= 1'b0;
      r_to_cnt      <= '0;
      r_ext_pending <= 1'b0;
      r_brk_pending <= 1'b0;
      r_jump_key    <= 1'b0;
      r_scan_code   <= 8'h00;
      r_scan_valid  <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_scan_valid <= w_ok;
      r_frame_err  <= w_err;

      if (r_state == IDLE)  r_bit_cnt <= 3'd0;
      else if (w_shift_en)  r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_shift_en) r_shift <= {r_dat_s2, r_shift[7:1]};
      if (w_fall && r_state == PARITY) r_par <= r_dat_s2;

      if (r_state == IDLE || w_fall || w_timeout) r_to_cnt <= '0;
      else                                        r_to_cnt <= r_to_cnt + 1'b1;

      if (w_ok) begin
        r_scan_code <= r_shift;
        if (r_shift == EXT_PFX) begin
          r_ext_pending <= 1'b1;
        end else if (r_shift == BRK_PFX) begin
          r_brk_pending <= 1'b1;
        end else begin
          if (r_shift == JUMP_CODE && !r_ext_pending) r_jump_key <= ~r_brk_pending;
          r_ext_pending <= 1'b0;
          r_brk_pending <= 1'b0;
        end
      end else if (w_err) begin
        r_ext_pending <= 1'b0;
        r_brk_pending <= 1'b0;
      end
    end
  end

  assign bus.jump_key   = r_jump_key;
  assign bus.scan_code  = r_scan_code;
  assign bus.scan_valid = r_scan_valid;
  assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_jump_decoder.sv
// Randomized PS/2 frames against a byte-level reference model of the jump-key decoder.
`timescale 1ns/1ps
module tb_ps2_jump_decoder;

  localparam int TO   = 1000;
  localparam int HALF = 20;   // 40 sysclk per PS/2 bit at 400 kHz sysclk -> 10 kHz ps2_clk
`ifdef PS2_CLK_FILTER_EN
  localparam int FLT = 8;
`else
  localparam int FLT = 0;
`endif
  localparam int LAT    = 3 + FLT;
  localparam int TO_LAT = TO + 3 + FLT;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  ps2_jump_decoder_if bus_if ();

  ps2_jump_decoder #(.JUMP_CODE(8'h29), .TIMEOUT_CYCLES(TO)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus_if)
  );

  always #1250 sysclk = ~sysclk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int sv_cnt = 0, err_cnt = 0, both_cnt = 0;
  int sv_cyc = 0, err_cyc = 0;
  int last_fall = 0;

  logic       m_jump;
  logic [7:0] m_code;
  logic       m_ext, m_brk;

  always @(posedge sysclk) cyc++;

  always @(negedge sysclk) begin
    if (bus_if.scan_valid) begin sv_cnt++;  sv_cyc  = cyc; end
    if (bus_if.frame_err)  begin err_cnt++; err_cyc = cyc; end
    if (bus_if.scan_valid && bus_if.frame_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic ps2_bit(input logic d);
    bus_if.ps2_data = d;
    wait_cyc(HALF);
    bus_if.ps2_clk = 1'b0;
    last_fall = cyc;
    wait_cyc(HALF);
    bus_if.ps2_clk = 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic ok);
    if (!ok) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else begin
      m_code = b;
      if (b == 8'hE0)      m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
        if (b == 8'h29 && !m_ext) m_jump = !m_brk;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end
    end
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b,
                            input logic bad_par, input logic bad_stop);
    int sv0, er0;
    logic ok;
    sv0 = sv_cnt;
    er0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(~bad_stop);
    bus_if.ps2_data = 1'b1;
    wait_cyc(HALF);
    ok = !bad_par && !bad_stop;
    model_byte(b, ok);
    chk({tag, "_sv"},   sv_cnt - sv0,   ok ? 1 : 0);
    chk({tag, "_err"},  err_cnt - er0,  ok ? 0 : 1);
    chk({tag, "_code"}, bus_if.scan_code, m_code);
    chk({tag, "_jump"}, bus_if.jump_key,  m_jump);
    if (ok) chk({tag, "_lat"}, sv_cyc - last_fall, LAT);
  endtask

  initial begin
    bus_if.ps2_clk  = 1'b1;
    bus_if.ps2_data = 1'b1;
    m_jump = 1'b0; m_code = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
    wait_cyc(3);
    chk("rst_jump",  bus_if.jump_key,   0);
    chk("rst_code",  bus_if.scan_code,  0);
    chk("rst_sv",    bus_if.scan_valid, 0);
    chk("rst_err",   bus_if.frame_err,  0);
    reset = 1'b0;
    wait_cyc(10);

    send_frame("make29", 8'h29, 1'b0, 1'b0);
    send_frame("brkF0",  8'hF0, 1'b0, 1'b0);
    send_frame("brk29",  8'h29, 1'b0, 1'b0);
    send_frame("make29b", 8'h29, 1'b0, 1'b0);
    send_frame("badpar", 8'h29, 1'b1, 1'b0);
    send_frame("badstop", 8'h1C, 1'b0, 1'b1);
    send_frame("brk2F0", 8'hF0, 1'b0, 1'b0);
    send_frame("brk229", 8'h29, 1'b0, 1'b0);
    send_frame("extE0",  8'hE0, 1'b0, 1'b0);
    send_frame("ext29",  8'h29, 1'b0, 1'b0);
    send_frame("code1C", 8'h1C, 1'b0, 1'b0);
    send_frame("after1C", 8'h29, 1'b0, 1'b0);
    send_frame("brk3F0", 8'hF0, 1'b0, 1'b0);
    send_frame("brk329", 8'h29, 1'b0, 1'b0);

    // Truncated frame: start + 3 data bits, then silence until timeout.
    begin
      int er0, sv0, waited;
      er0 = err_cnt; sv0 = sv_cnt;
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
      bus_if.ps2_data = 1'b1;
      waited = 0;
      while (err_cnt == er0 && waited < 3 * TO) begin
        wait_cyc(1);
        waited++;
      end
      chk("to_err", err_cnt - er0, 1);
      chk("to_lat", err_cyc - last_fall, TO_LAT);
      chk("to_sv",  sv_cnt - sv0, 0);
      model_byte(8'h00, 1'b0);
      wait_cyc(10);
    end
    send_frame("to_next", 8'h29, 1'b0, 1'b0);

    // Short low glitch on ps2_clk while idle.
    begin
      int er0, sv0;
      er0 = err_cnt; sv0 = sv_cnt;
      bus_if.ps2_clk = 1'b0;
      wait_cyc(3);
      bus_if.ps2_clk = 1'b1;
      wait_cyc(40);
      chk("glitch_err", err_cnt - er0, (FLT != 0) ? 0 : 1);
      chk("glitch_sv",  sv_cnt - sv0, 0);
      if (FLT == 0) model_byte(8'h00, 1'b0);
    end
    send_frame("glitch_next", 8'h1C, 1'b0, 1'b0);

    // Reset in the middle of a frame.
    begin
      int er0;
      er0 = err_cnt;
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
      bus_if.ps2_data = 1'b1;
      reset = 1'b1;
      wait_cyc(2);
      reset = 1'b0;
      m_jump = 1'b0; m_code = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
      wait_cyc(TO + 200);
      chk("mrst_err",  err_cnt - er0, 0);
      chk("mrst_jump", bus_if.jump_key, 0);
      chk("mrst_code", bus_if.scan_code, 0);
    end
    send_frame("mrst_next", 8'h29, 1'b0, 1'b0);

    for (int n = 0; n < 36; n++) begin
      int sel;
      logic [7:0] b;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: b = 8'h29;
        3:       b = 8'hF0;
        4:       b = 8'hE0;
        5:       b = 8'h1C;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_frame("rnd", b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end

    chk("excl", both_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #(64'd250_000_000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
